ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter PC_DW, default 32, meaning PC width.
REQ-002 SHALL have parameter INST_DW, default 32, meaning instruction width; sequential PC step is INST_DW/8.
REQ-003 SHALL have parameter DEPTH, default 4, meaning fetch-buffer entries and maximum in-flight plus buffered requests; power of 2, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; asynchronous and active-low.
REQ-007 SHALL have port redirect_valid, input, 1 bit, which requests a fetch-stream restart.
REQ-008 SHALL have port redirect_pc, input, PC_DW bits, the restart address.
REQ-009 SHALL have port req_valid, output, 1 bit, a memory fetch request.
REQ-010 SHALL have port req_ready, input, 1 bit; memory accepts the request when both req_valid and req_ready are high.
REQ-011 SHALL have port req_addr, output, PC_DW bits, the fetch address.
REQ-012 SHALL have port rsp_valid, input, 1 bit, which returns response data in request order; there is no backpressure.
REQ-013 SHALL have port rsp_data, input, INST_DW bits, the fetched instruction.
REQ-014 SHALL have port out_valid, output, 1 bit; the buffer head is valid.
REQ-015 SHALL have port out_ready, input, 1 bit, which the consumer drives to accept the head.
REQ-016 SHALL have port out_pc, output, PC_DW bits, the PC of the head instruction.
REQ-017 SHALL have port out_instr, output, INST_DW bits, the head instruction.

Function
REQ-018 SHALL keep the following state: fetch_pc (next request address), rsp_pc (PC of next non-stale response), a FIFO of {pc, instr} with DEPTH entries, an outstanding counter (0..DEPTH), and a discard counter (0..DEPTH).
REQ-019 SHALL assert req_valid exactly when FIFO count plus outstanding is less than DEPTH and redirect_valid is low; req_addr SHALL equal fetch_pc.
REQ-020 SHALL hold req_valid and req_addr stable while req_valid is high and req_ready is low, unless a redirect occurs.
REQ-021 SHALL, on a request handshake, increment fetch_pc by INST_DW/8 (mod 2^PC_DW) and increment outstanding.
REQ-022 SHALL, on rsp_valid, decrement outstanding; if discard is nonzero the response is dropped and discard decrements; otherwise {rsp_pc, rsp_data} is written to the FIFO and rsp_pc is incremented by INST_DW/8.
REQ-023 SHALL never overflow the FIFO, because it is credit-guaranteed by REQ-019; an rsp_valid with outstanding equal to 0 is illegal stimulus.
REQ-024 SHALL drive out_valid high when the FIFO is non-empty; out_pc and out_instr are the head entry; an output handshake pops the head.
REQ-025 SHALL make a response visible on out_* no earlier than the cycle after rsp_valid, with no combinational path from rsp to out.
REQ-026 SHALL keep out_pc and out_instr stable while out_valid is high and out_ready is low, absent a redirect.
REQ-027 SHALL, on redirect_valid (highest priority), do all of the following: flush the FIFO (count to 0); set fetch_pc and rsp_pc to redirect_pc; set discard to outstanding minus (1 if rsp_valid this cycle), plus the discard already pending is not double counted; and issue no request that cycle.
REQ-028 SHALL drop a same-cycle rsp_valid on a redirect, and SHALL ignore a same-cycle out_ready on a redirect because the entry is flushed.
REQ-029 SHALL resume requests on the cycle after the redirect with req_addr equal to redirect_pc, subject to credit; stale in-flight responses consume credit until they are discarded.
REQ-030 SHALL treat back-to-back redirects so that the last one wins, with discard recomputed each time per REQ-027.
REQ-031 SHALL let FIFO pointers wrap modulo DEPTH, with count tracked separately so that full and empty are distinguishable.

Reset
REQ-032 SHALL, while rst is low, asynchronously force fetch_pc and rsp_pc to RESET_PC; FIFO count, pointers, outstanding and discard to 0; and req_valid and out_valid to 0.
REQ-033 SHALL assert req_valid with req_addr equal to RESET_PC in the first cycle after rst deasserts.
REQ-034 SHALL, on a mid-operation reset, discard all in-flight state; the bench guarantees the memory model is also reset.

Verification
REQ-035 SHALL be covered by a streaming scenario: DEPTH=4, req_ready=1, 1-cycle memory, out_ready=1 -> out_pc is 8000_0000, 8000_0004, 8000_0008 … on consecutive cycles, with instr matching memory.
REQ-036 SHALL be covered by a backpressure scenario: out_ready=0 -> 4 entries fill, req_valid drops to 0 with outstanding 0; raise out_ready -> requests resume at 8000_0010.
REQ-037 SHALL be covered by a redirect-with-in-flight scenario: 3-cycle memory latency, 2 outstanding, redirect to 8000_1000 -> both stale responses dropped, first out_pc is 8000_1000.
REQ-038 SHALL be covered by a redirect coinciding with rsp_valid and out handshake: that response is dropped, the FIFO is empty next cycle, and discard equals outstanding-1.
REQ-039 SHALL be covered by a wrap scenario: redirect_pc FFFF_FFFC, PC_DW=32 -> out_pc sequence FFFF_FFFC then 0000_0000.
REQ-040 SHALL be covered by a reset-mid-stream scenario: rst low with FIFO full -> out_valid 0 immediately; after release req_addr is 8000_0000.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit with a credit-limited fetch buffer.
//
// Issues sequential fetch requests starting at RESET_PC. Responses return in
// request order and are written into a DEPTH-entry FIFO together with their
// PC. A redirect restarts the stream at redirect_pc. Responses still in flight
// at the time of a redirect are counted and dropped when they arrive.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   redirect_valid restart the fetch stream (highest priority)
//   redirect_pc    restart address
//   req_valid      fetch request to memory
//   req_ready      memory accepts the request
//   req_addr       fetch address
//   rsp_valid      in-order response strobe (no backpressure)
//   rsp_data       fetched instruction
//   out_valid      buffer head valid
//   out_ready      consumer accepts the head
//   out_pc         PC of the head instruction
//   out_instr      head instruction
module ifu_prefetch #(
  parameter int                PC_DW    = 32,
  parameter int                INST_DW  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [PC_DW-1:0]  RESET_PC = 'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_DW-1:0]   redirect_pc,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [PC_DW-1:0]   req_addr,
  input  logic               rsp_valid,
  input  logic [INST_DW-1:0] rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_DW-1:0]   out_pc,
  output logic [INST_DW-1:0] out_instr
);

  localparam int                 CNT_W   = $clog2(DEPTH + 1);
  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam logic [PC_DW-1:0]   PC_STEP = PC_DW'(INST_DW / 8);
  localparam logic [CNT_W:0]     DEPTH_C = (CNT_W + 1)'(DEPTH);

  function automatic logic [PC_DW-1:0] pc_inc(input logic [PC_DW-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Control state
  logic [PC_DW-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_DW-1:0] rsp_pc, rsp_pc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic [CNT_W-1:0] discard, discard_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;

  // Buffer storage (data only, never reset)
  logic [PC_DW-1:0]   pc_mem    [DEPTH];
  logic [INST_DW-1:0] instr_mem [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           rsp_take;
  logic           pop;

  // Buffered entries plus in-flight requests (stale ones included) consume
  // credit, which is what guarantees the FIFO can never overflow.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  // Gating with rst keeps req_valid low while reset is held, independent of
  // the clock.
  assign req_valid   = rst & ~redirect_valid & (credit_used < DEPTH_C);
  assign req_addr    = fetch_pc;
  assign req_fire    = req_valid & req_ready;

  assign out_valid   = (count != '0);
  assign out_pc      = pc_mem[rd_ptr];
  assign out_instr   = instr_mem[rd_ptr];

  // A redirect flushes the buffer, so neither a response write nor a pop
  // may take effect in that cycle.
  assign rsp_take    = rsp_valid & ~redirect_valid & (discard == '0);
  assign pop         = out_valid & out_ready & ~redirect_valid;

  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    count_nxt       = count;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;

    // req_fire is already suppressed during a redirect.
    if (req_fire && !rsp_valid) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!req_fire && rsp_valid) begin
      outstanding_nxt = outstanding - 1'b1;
    end

    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc;
      rsp_pc_nxt   = redirect_pc;
      count_nxt    = '0;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      // Every request still in flight after this edge is stale. Recomputing
      // from outstanding (rather than adding to discard) avoids counting
      // responses already marked stale by an earlier redirect twice.
      discard_nxt  = rsp_valid ? outstanding - 1'b1 : outstanding;
    end else begin
      if (req_fire) begin
        fetch_pc_nxt = pc_inc(fetch_pc);
      end
      if (rsp_valid && (discard != '0)) begin
        discard_nxt = discard - 1'b1;
      end
      if (rsp_take) begin
        rsp_pc_nxt = pc_inc(rsp_pc);
        wr_ptr_nxt = wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + 1'b1;
      end
      if (rsp_take && !pop) begin
        count_nxt = count + 1'b1;
      end else if (!rsp_take && pop) begin
        count_nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
    end
  end

  // Response capture: registered, so data appears on out_* one cycle later.
  always_ff @(posedge clk) begin
    if (rsp_take) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: table-driven streaming/backpressure vectors,
// hand-written redirect/wrap/reset sequences, and a randomized run against
// a queue-based reference model with an in-order memory model.
module tb_ifu_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  ifu_prefetch #(
    .PC_DW(32), .INST_DW(32), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Memory / reference model: requests in flight (with a stale mark set by a
  // redirect) and the instructions the consumer should see, in order.
  typedef struct { logic [31:0] addr; int due; bit stale; } inflight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  inflight_t   mq[$];
  entry_t      buffer[$];
  logic [31:0] m_fetch_pc;
  int          last_due;
  int          lat;
  int          cyc;

  int checks = 0;
  int errors = 0;

  bit          s_rv, s_ov;
  logic [31:0] s_ra, s_opc, s_oin;

  typedef struct {
    bit rr; bit ordy;
    bit e_rv; logic [31:0] e_ra;
    bit e_ov; logic [31:0] e_opc;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for out_valid (cycle %0d)", name, cyc);
  endtask

  // One clock cycle: drive inputs, sample and check outputs, advance model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rr, input bit ordy);
    bit rsp, e_rv, e_ov;
    int due;
    redirect_valid = redir;
    redirect_pc    = rpc;
    req_ready      = rr;
    out_ready      = ordy;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_valid = rsp;
    rsp_data  = rsp ? mem_data(mq[0].addr) : 32'h0;
    #2;
    e_rv = !redir && ((buffer.size() + mq.size()) < DEPTH);
    e_ov = buffer.size() > 0;
    s_rv = req_valid; s_ra = req_addr; s_ov = out_valid; s_opc = out_pc; s_oin = out_instr;
    check("req_valid", 32'(s_rv), 32'(e_rv));
    if (e_rv) check("req_addr", s_ra, m_fetch_pc);
    check("out_valid", 32'(s_ov), 32'(e_ov));
    if (e_ov) begin
      check("out_pc", s_opc, buffer[0].pc);
      check("out_instr", s_oin, buffer[0].instr);
    end
    if (redir) begin
      buffer.delete();
      if (rsp) void'(mq.pop_front());
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_fetch_pc = rpc;
    end else begin
      if (e_ov && ordy) void'(buffer.pop_front());
      if (rsp) begin
        inflight_t f;
        entry_t e;
        f = mq.pop_front();
        if (!f.stale) begin
          e.pc = f.addr;
          e.instr = mem_data(f.addr);
          buffer.push_back(e);
        end
      end
      if (e_rv && rr) begin
        inflight_t n;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        n.addr = m_fetch_pc; n.due = due; n.stale = 1'b0;
        mq.push_back(n);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset immediately (asynchronously), checks outputs drop without
  // a clock edge, then releases reset on a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'h0; out_ready = 1'b0;
    #1;
    check("reset_req_valid", 32'(req_valid), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(posedge clk);
    mq.delete();
    buffer.delete();
    m_fetch_pc = 32'h8000_0000;
    last_due = cyc;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_out(input string name, input logic [31:0] pc, input int bound);
    int n;
    n = 0;
    while (!s_ov && n < bound) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      n++;
    end
    if (s_ov) check(name, s_opc, pc);
    else fail_timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    //          rr    ordy  e_rv  e_ra          e_ov  e_opc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0010};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0010};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0014};

    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'h0; out_ready = 1'b0;
    cyc = 0; lat = 1; last_due = 0; m_fetch_pc = 32'h8000_0000;
    #3;

    // Streaming with 1-cycle memory, then backpressure and release.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, tbl[i].rr, tbl[i].ordy);
      check("tbl_req_valid", 32'(s_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) check("tbl_req_addr", s_ra, tbl[i].e_ra);
      check("tbl_out_valid", 32'(s_ov), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) check("tbl_out_pc", s_opc, tbl[i].e_opc);
    end

    // Backpressure from reset: four entries fill, requests stop, resume at +0x10.
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_stalled_req_valid", 32'(s_rv), 32'h0);
    check("bp_head_pc", s_opc, 32'h8000_0000);
    n = 0;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    while (!s_rv && n < 5) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      n++;
    end
    check("bp_resume_addr", s_rv ? s_ra : 32'hDEAD_BEEF, 32'h8000_0010);

    // Redirect with two stale responses in flight (3-cycle memory).
    do_reset();
    lat = 3;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_1000, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_req_valid", 32'(s_rv), 32'h1);
    check("redir_req_addr", s_ra, 32'h8000_1000);
    wait_out("redir_first_out_pc", 32'h8000_1000, 15);

    // Redirect coinciding with a response and an output handshake (2-cycle
    // memory, two outstanding so exactly one stale response must be dropped).
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_2000, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("coinc_out_valid_flushed", 32'(s_ov), 32'h0);
    check("coinc_req_addr", s_ra, 32'h8000_2000);
    wait_out("coinc_first_out_pc", 32'h8000_2000, 15);

    // PC wrap.
    do_reset();
    lat = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    wait_out("wrap_first_pc", 32'hFFFF_FFFC, 10);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    wait_out("wrap_second_pc", 32'h0000_0000, 10);

    // Reset mid-stream with the FIFO full.
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("full_out_valid", 32'(s_ov), 32'h1);
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("post_reset_req_valid", 32'(s_rv), 32'h1);
    check("post_reset_req_addr", s_ra, 32'h8000_0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit redir, rr, ordy;
      logic [31:0] rpc;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      if (i % 1000 == 999) do_reset();
      redir = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      rr = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(redir, rpc, rr, ordy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
